// File: rtl/mkio_pkg.sv
// Shared types and helpers for the MKIO channel multiplexer.
package mkio_pkg;

  // Mux operating modes: listening, following one channel, sending, post-send quiet period.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    TX     = 2'd2,
    HOLD   = 2'd3
  } mux_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mkio_line_sync.sv
// Two-flop synchroniser for one MKIO line pair (di1/di0) into the clk domain.
module mkio_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic di1,
  input  logic di0,
  output logic s_di1,
  output logic s_di0
);

  logic meta1;
  logic meta0;

  // Two-stage capture of the asynchronous line levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta1 <= 1'b0;
      meta0 <= 1'b0;
      s_di1 <= 1'b0;
      s_di0 <= 1'b0;
    end else begin
      meta1 <= di1;
      meta0 <= di0;
      s_di1 <= meta1;
      s_di0 <= meta0;
    end
  end

endmodule

// File: rtl/mkio_channel_mux.sv
// N-channel MKIO line multiplexer: merges receive lines into one core, locks onto
// the channel carrying traffic, transmits only on that channel and keeps its
// receiver blanked for a hold-off period after each transmission.
module mkio_channel_mux
  import mkio_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int HOLD_CYCLES  = 5,
  parameter int IDLE_TIMEOUT = 64,
  localparam int CH_W        = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] di1,
  input  logic [N_CH-1:0] di0,
  output logic [N_CH-1:0] do1,
  output logic [N_CH-1:0] do0,
  output logic [N_CH-1:0] rx_strob,
  output logic [N_CH-1:0] tx_inhibit,
  input  logic [N_CH-1:0] ch_en,
  output logic            core_di1,
  output logic            core_di0,
  input  logic            core_do1,
  input  logic            core_do0,
  input  logic            tx_busy,
  output logic [CH_W-1:0] active_ch,
  output logic            locked,
  output logic            tx_active,
  output logic [N_CH-1:0] conflict,
  input  logic            conflict_clr,
  output logic [1:0]      state_dbg
);

  localparam int SIL_W  = clog2_min1(IDLE_TIMEOUT);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES + 1);
  localparam logic [SIL_W-1:0]  SIL_LAST  = SIL_W'(IDLE_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [N_CH-1:0]   s_di1;
  logic [N_CH-1:0]   s_di0;
  logic [N_CH-1:0]   act;
  logic [N_CH-1:0]   cur_oh;
  logic [N_CH-1:0]   nxt_oh;
  logic [CH_W-1:0]   first_ch;
  logic              en_cur;
  logic              act_cur;
  logic              busy_q;
  logic              busy_rise;
  logic              nxt_txhold;

  mux_state_t        state;
  mux_state_t        nxt;
  logic [CH_W-1:0]   nxt_ch;
  logic [SIL_W-1:0]  sil_cnt;
  logic [SIL_W-1:0]  nxt_sil;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] nxt_hold;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    mkio_line_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .di1   (di1[g]),
      .di0   (di0[g]),
      .s_di1 (s_di1[g]),
      .s_di0 (s_di0[g])
    );
  end

  assign act       = (s_di1 | s_di0) & ch_en;
  assign cur_oh    = N_CH'(1) << active_ch;
  assign nxt_oh    = N_CH'(1) << nxt_ch;
  assign en_cur    = |(ch_en & cur_oh);
  assign act_cur   = |(act & cur_oh);
  assign busy_rise = tx_busy & ~busy_q;
  assign nxt_txhold = (nxt == TX) || (nxt == HOLD);

  assign locked    = (state != IDLE);
  assign tx_active = (state == TX) || (state == HOLD);
  assign state_dbg = state;

  // Lowest-index enabled channel showing activity; wins simultaneous starts.
  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (act[i]) first_ch = CH_W'(i);
    end
  end

  // Next mode, locked channel and counters.
  always_comb begin
    nxt      = state;
    nxt_ch   = active_ch;
    nxt_sil  = sil_cnt;
    nxt_hold = hold_cnt;
    case (state)
      IDLE: begin
        if (busy_rise) begin
          nxt = TX;
        end else if (|act) begin
          nxt     = LOCKED;
          nxt_ch  = first_ch;
          nxt_sil = '0;
        end
      end
      LOCKED: begin
        // A channel being disabled drops the lock even mid-request to send.
        if (!en_cur) begin
          nxt = IDLE;
        end else if (tx_busy) begin
          nxt = TX;
        end else if (act_cur) begin
          nxt_sil = '0;
        end else if (sil_cnt == SIL_LAST) begin
          nxt = IDLE;
        end else begin
          nxt_sil = sil_cnt + 1'b1;
        end
      end
      TX: begin
        if (!tx_busy) begin
          nxt      = HOLD;
          nxt_hold = '0;
        end
      end
      HOLD: begin
        if (busy_rise) begin
          nxt = TX;
        end else if (hold_cnt == HOLD_LAST) begin
          nxt     = LOCKED;
          nxt_sil = '0;
        end else begin
          nxt_hold = hold_cnt + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Mode, channel and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      active_ch <= '0;
      sil_cnt   <= '0;
      hold_cnt  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= nxt;
      active_ch <= nxt_ch;
      sil_cnt   <= nxt_sil;
      hold_cnt  <= nxt_hold;
      busy_q    <= tx_busy;
    end
  end

  // Registered line outputs; transmit-side outputs follow the mode being entered
  // so the first transmitted bit is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      do1        <= '0;
      do0        <= '0;
      rx_strob   <= '0;
      tx_inhibit <= '1;
      core_di1   <= 1'b0;
      core_di0   <= 1'b0;
    end else begin
      do1        <= (nxt == TX) ? (nxt_oh & ch_en & {N_CH{core_do1}}) : '0;
      do0        <= (nxt == TX) ? (nxt_oh & ch_en & {N_CH{core_do0}}) : '0;
      rx_strob   <= ch_en & ~(nxt_txhold ? nxt_oh : {N_CH{1'b0}});
      tx_inhibit <= ~((nxt == TX) ? nxt_oh : {N_CH{1'b0}});
      case (state)
        IDLE: begin
          core_di1 <= |(s_di1 & ch_en);
          core_di0 <= |(s_di0 & ch_en);
        end
        LOCKED: begin
          core_di1 <= |(s_di1 & ch_en & cur_oh);
          core_di0 <= |(s_di0 & ch_en & cur_oh);
        end
        default: begin
          core_di1 <= 1'b0;
          core_di0 <= 1'b0;
        end
      endcase
    end
  end

  // Sticky cross-channel activity flags; a new hit outranks a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= '0;
    end else begin
      conflict <= (conflict & ~{N_CH{conflict_clr}})
                | ((state != IDLE) ? (act & ~cur_oh) : {N_CH{1'b0}});
    end
  end

endmodule

// File: tb/tb_mkio_channel_mux.sv
// Bench for mkio_channel_mux with three channels: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the multiplexer.
module tb_mkio_channel_mux;

  localparam int N  = 3;
  localparam int HC = 5;
  localparam int TO = 64;
  localparam int CW = 2;
  localparam int W  = 5 * N + CW + 4;

  localparam int M_IDLE   = 0;
  localparam int M_LOCKED = 1;
  localparam int M_TX     = 2;
  localparam int M_HOLD   = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  di1, di0, do1, do0, rx_strob, tx_inhibit, ch_en, conflict;
  logic          core_di1, core_di0, core_do1, core_do0, tx_busy;
  logic [CW-1:0] active_ch;
  logic          locked, tx_active, conflict_clr;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mkio_channel_mux #(.N_CH(N), .HOLD_CYCLES(HC), .IDLE_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .di1          (di1),
    .di0          (di0),
    .do1          (do1),
    .do0          (do0),
    .rx_strob     (rx_strob),
    .tx_inhibit   (tx_inhibit),
    .ch_en        (ch_en),
    .core_di1     (core_di1),
    .core_di0     (core_di0),
    .core_do1     (core_do1),
    .core_do0     (core_do0),
    .tx_busy      (tx_busy),
    .active_ch    (active_ch),
    .locked       (locked),
    .tx_active    (tx_active),
    .conflict     (conflict),
    .conflict_clr (conflict_clr),
    .state_dbg    (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_state = M_IDLE;
  int           m_ch = 0;
  int           m_quiet = 0;
  int           m_hold_left = 0;
  bit           m_busy_prev = 1'b0;
  logic [N-1:0] h1a = '0, h0a = '0, h1b = '0, h0b = '0;
  logic [N-1:0] m_conf = '0, m_do1 = '0, m_do0 = '0, m_rx = '0, m_txi = '1;
  logic         m_cd1 = 1'b0, m_cd0 = 1'b0;

  always @(posedge clk) begin : model
    logic [N-1:0] seen;
    bit rise;
    int low;
    if (reset) begin
      m_state = M_IDLE; m_ch = 0; m_quiet = 0; m_hold_left = 0; m_busy_prev = 1'b0;
      h1a = '0; h0a = '0; h1b = '0; h0b = '0;
      m_conf = '0; m_do1 = '0; m_do0 = '0; m_rx = '0; m_txi = '1;
      m_cd1 = 1'b0; m_cd0 = 1'b0;
    end else begin
      // lines as seen by the block this edge: the levels from two clocks ago
      seen = (h1b | h0b) & ch_en;
      if (m_state == M_IDLE) begin
        m_cd1 = |(h1b & ch_en);
        m_cd0 = |(h0b & ch_en);
      end else if (m_state == M_LOCKED) begin
        m_cd1 = h1b[m_ch] & ch_en[m_ch];
        m_cd0 = h0b[m_ch] & ch_en[m_ch];
      end else begin
        m_cd1 = 1'b0;
        m_cd0 = 1'b0;
      end
      if (conflict_clr) m_conf = '0;
      if (m_state != M_IDLE)
        for (int i = 0; i < N; i++) if (i != m_ch && seen[i]) m_conf[i] = 1'b1;
      rise = tx_busy && !m_busy_prev;
      case (m_state)
        M_IDLE: begin
          if (rise) m_state = M_TX;
          else if (seen != 0) begin
            low = 0;
            for (int i = N - 1; i >= 0; i--) if (seen[i]) low = i;
            m_ch = low; m_state = M_LOCKED; m_quiet = 0;
          end
        end
        M_LOCKED: begin
          if (!ch_en[m_ch]) m_state = M_IDLE;
          else if (tx_busy) m_state = M_TX;
          else if (seen[m_ch]) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == TO) m_state = M_IDLE;
          end
        end
        M_TX: begin
          if (!tx_busy) begin m_state = M_HOLD; m_hold_left = HC; end
        end
        default: begin
          if (rise) m_state = M_TX;
          else begin
            m_hold_left--;
            if (m_hold_left == 0) begin m_state = M_LOCKED; m_quiet = 0; end
          end
        end
      endcase
      m_busy_prev = tx_busy;
      m_do1 = '0; m_do0 = '0; m_txi = '1; m_rx = ch_en;
      if (m_state == M_TX) begin
        m_txi[m_ch] = 1'b0;
        if (ch_en[m_ch]) begin m_do1[m_ch] = core_do1; m_do0[m_ch] = core_do0; end
      end
      if (m_state == M_TX || m_state == M_HOLD) m_rx[m_ch] = 1'b0;
      h1b = h1a; h0b = h0a; h1a = di1; h0a = di0;
    end
    exp_q.push_back({m_do1, m_do0, m_rx, m_txi, m_cd1, m_cd0, CW'(m_ch),
                     m_state != M_IDLE, m_state == M_TX || m_state == M_HOLD, m_conf});
  end

  // ---------------- scoreboard ----------------
  initial begin : scoreboard
    logic [W-1:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      got = {do1, do0, rx_strob, tx_inhibit, core_di1, core_di0, active_ch,
             locked, tx_active, conflict};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cycle_outputs: no expectation queued at %0t", $time);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL cycle_outputs: got %b expected %b at %0t", got, want, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int rise_at, gone_at;
    int dens[N];
    reset = 1'b1; di1 = '0; di0 = '0; ch_en = '1; core_do1 = 1'b0; core_do0 = 1'b0;
    tx_busy = 1'b0; conflict_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_inhibit", tx_inhibit, 3'b111);
    check("reset_rx_strob", rx_strob, 3'b000);
    check("reset_do1", do1, 3'b000);
    check("reset_locked", locked, 1'b0);
    check("reset_core_di", {core_di1, core_di0}, 2'b00);
    reset = 1'b0;
    ch_en = 3'b011;
    repeat (3) @(negedge clk);

    // lock onto channel 1, then a pulse on channel 0 raises its conflict flag
    di1 = 3'b010;
    step(); step();
    check("lock_not_before_third_edge", locked, 1'b0);
    step();
    check("lock_ch1_locked", locked, 1'b1);
    check("lock_ch1_active_ch", active_ch, 2'd1);
    check("lock_ch1_first_word", core_di1, 1'b1);
    @(negedge clk); di0 = 3'b001;
    @(negedge clk); di0 = 3'b000;
    step(); step();
    check("conflict_ch0", conflict, 3'b001);
    check("core_di0_ignores_ch0", core_di0, 1'b0);
    check("core_di1_follows_ch1", core_di1, 1'b1);
    @(negedge clk); conflict_clr = 1'b1;
    @(negedge clk); conflict_clr = 1'b0; di1 = '0;
    check("conflict_cleared", conflict, 3'b000);

    // transmit on channel 1 for 20 cycles, then hold-off
    @(negedge clk); tx_busy = 1'b1; core_do1 = 1'b1;
    step();
    check("tx_inhibit_ch1_only", tx_inhibit, 3'b101);
    check("tx_rx_strob_blank", rx_strob, 3'b001);
    check("tx_do1_on_ch1", do1, 3'b010);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      core_do1 = 1'($urandom_range(0, 1));
      core_do0 = 1'($urandom_range(0, 1));
    end
    @(negedge clk); tx_busy = 1'b0; core_do1 = 1'b0; core_do0 = 1'b0;
    rise_at = 0;
    for (int k = 1; k <= 20 && rise_at == 0; k++) begin
      step();
      if (rx_strob[1]) rise_at = k;
    end
    check("rx_strob_rise_after_busy_fall", rise_at, HC + 1);

    // silence on the locked channel releases the lock
    gone_at = 0;
    for (int k = 1; k <= 200 && gone_at == 0; k++) begin
      step();
      if (!locked) gone_at = k;
    end
    check("silence_timeout_cycles", gone_at, TO);

    // lock on channel 0, then disable it
    @(negedge clk); di0 = 3'b001;
    step(); step(); step();
    check("lock_ch0_active_ch", active_ch, 2'd0);
    check("lock_ch0_locked", locked, 1'b1);
    @(negedge clk); ch_en = 3'b010;
    step();
    check("disable_drops_lock", locked, 1'b0);
    @(negedge clk); di0 = '0;
    repeat (3) @(negedge clk);

    // activity on a disabled channel is ignored
    ch_en = 3'b001; di1 = 3'b010;
    repeat (5) @(negedge clk);
    check("disabled_no_lock", locked, 1'b0);
    check("disabled_no_core_di", core_di1, 1'b0);
    check("disabled_no_conflict", conflict, 3'b000);
    di1 = '0;
    repeat (3) @(negedge clk);

    // simultaneous start on channels 0 and 2
    ch_en = 3'b111;
    @(negedge clk); di1 = 3'b101;
    step(); step(); step();
    check("tie_lowest_index", active_ch, 2'd0);
    check("tie_locked", locked, 1'b1);
    step();
    check("tie_conflict_ch2", conflict, 3'b100);

    // reset in the middle of a transmission
    @(negedge clk); di1 = '0; tx_busy = 1'b1; core_do1 = 1'b1;
    step();
    check("tx_ch0_do1", do1, 3'b001);
    @(negedge clk); reset = 1'b1;
    #1;
    check("async_reset_do1", do1, 3'b000);
    check("async_reset_tx_inhibit", tx_inhibit, 3'b111);
    check("async_reset_tx_active", tx_active, 1'b0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0; tx_busy = 1'b0; core_do1 = 1'b0;
    step();
    check("post_reset_state_idle", state_dbg, 2'd0);
    check("post_reset_active_ch", active_ch, 2'd0);
    check("post_reset_rx_strob", rx_strob, 3'b111);

    // randomized traffic
    for (int i = 0; i < N; i++) dens[i] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0) begin
        for (int i = 0; i < N; i++) begin
          case ($urandom_range(0, 2))
            0: dens[i] = 0;
            1: dens[i] = 4;
            default: dens[i] = 30;
          endcase
        end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < dens[i]) begin
          di1[i] = 1'($urandom_range(0, 1));
          di0[i] = ~di1[i];
        end else begin
          di1[i] = 1'b0;
          di0[i] = 1'b0;
        end
      end
      if (tx_busy) begin
        if ($urandom_range(0, 14) == 0) tx_busy = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        tx_busy = 1'b1;
      end
      core_do1 = 1'($urandom_range(0, 1));
      core_do0 = 1'($urandom_range(0, 1));
      conflict_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) ch_en = 3'($urandom_range(1, 7));
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 799) == 0) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0; tx_busy = 1'b0; di1 = '0; di0 = '0; conflict_clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
